// File: rtl/crypto_instr_pkg.sv
// Shared types and constants for the crypto unit's SHA-2 sigma/sum pipeline.
// Rotate/shift amounts are the FIPS 180-4 constants.
package crypto_instr_pkg;

    localparam int CRYPTO_XLEN = 64;
    localparam int DATA_W      = 64;
    // Widest transaction id the stage struct can carry.
    localparam int TAG_W_MAX   = 8;

    typedef enum logic [2:0] {
        SHA256_SUM0 = 3'd0,
        SHA256_SUM1 = 3'd1,
        SHA256_SIG0 = 3'd2,
        SHA256_SIG1 = 3'd3,
        SHA512_SUM0 = 3'd4,
        SHA512_SUM1 = 3'd5,
        SHA512_SIG0 = 3'd6,
        SHA512_SIG1 = 3'd7
    } sha2_op_e;

    localparam int SHA256_SUM0_R0 = 2;
    localparam int SHA256_SUM0_R1 = 13;
    localparam int SHA256_SUM0_R2 = 22;
    localparam int SHA256_SUM1_R0 = 6;
    localparam int SHA256_SUM1_R1 = 11;
    localparam int SHA256_SUM1_R2 = 25;
    localparam int SHA256_SIG0_R0 = 7;
    localparam int SHA256_SIG0_R1 = 18;
    localparam int SHA256_SIG0_SH = 3;
    localparam int SHA256_SIG1_R0 = 17;
    localparam int SHA256_SIG1_R1 = 19;
    localparam int SHA256_SIG1_SH = 10;

    localparam int SHA512_SUM0_R0 = 28;
    localparam int SHA512_SUM0_R1 = 34;
    localparam int SHA512_SUM0_R2 = 39;
    localparam int SHA512_SUM1_R0 = 14;
    localparam int SHA512_SUM1_R1 = 18;
    localparam int SHA512_SUM1_R2 = 41;
    localparam int SHA512_SIG0_R0 = 1;
    localparam int SHA512_SIG0_R1 = 8;
    localparam int SHA512_SIG0_SH = 7;
    localparam int SHA512_SIG1_R0 = 19;
    localparam int SHA512_SIG1_R1 = 61;
    localparam int SHA512_SIG1_SH = 6;

    typedef struct packed {
        sha2_op_e              op;
        logic [DATA_W-1:0]     data;
        logic [TAG_W_MAX-1:0]  tag;
        logic                  illegal;
    } sha2_stage_t;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/crypto_sha2_core.sv
// Combinational SHA-2 sigma/sum datapath: op + rs1 -> result, illegal.
// SHA-512 ops are only elaborated when CRYPTO_SHA512_EN is defined.
module crypto_sha2_core
    import crypto_instr_pkg::*;
#(
    parameter int XLEN = CRYPTO_XLEN
) (
    input  sha2_op_e        op,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    logic [63:0] x;
    logic [31:0] w;
    logic [31:0] r256;
    logic [63:0] res64;

    assign x = 64'(rs1);
    assign w = x[31:0];

    always_comb begin
        r256 = '0;
        case (op)
            SHA256_SUM0: r256 = ror32(w, SHA256_SUM0_R0) ^ ror32(w, SHA256_SUM0_R1)
                              ^ ror32(w, SHA256_SUM0_R2);
            SHA256_SUM1: r256 = ror32(w, SHA256_SUM1_R0) ^ ror32(w, SHA256_SUM1_R1)
                              ^ ror32(w, SHA256_SUM1_R2);
            SHA256_SIG0: r256 = ror32(w, SHA256_SIG0_R0) ^ ror32(w, SHA256_SIG0_R1)
                              ^ (w >> SHA256_SIG0_SH);
            SHA256_SIG1: r256 = ror32(w, SHA256_SIG1_R0) ^ ror32(w, SHA256_SIG1_R1)
                              ^ (w >> SHA256_SIG1_SH);
            default:     r256 = '0;
        endcase
    end

    // 256-bit results are sign-extended from bit 31; truncation handles XLEN = 32.
    always_comb begin
        res64   = '0;
        illegal = 1'b0;
        if (!op[2]) begin
            res64 = {{32{r256[31]}}, r256};
        end else begin
`ifdef CRYPTO_SHA512_EN
            if (XLEN == 64) begin
                case (op)
                    SHA512_SUM0: res64 = ror64(x, SHA512_SUM0_R0) ^ ror64(x, SHA512_SUM0_R1)
                                       ^ ror64(x, SHA512_SUM0_R2);
                    SHA512_SUM1: res64 = ror64(x, SHA512_SUM1_R0) ^ ror64(x, SHA512_SUM1_R1)
                                       ^ ror64(x, SHA512_SUM1_R2);
                    SHA512_SIG0: res64 = ror64(x, SHA512_SIG0_R0) ^ ror64(x, SHA512_SIG0_R1)
                                       ^ (x >> SHA512_SIG0_SH);
                    default:     res64 = ror64(x, SHA512_SIG1_R0) ^ ror64(x, SHA512_SIG1_R1)
                                       ^ (x >> SHA512_SIG1_SH);
                endcase
            end else begin
                illegal = 1'b1;
            end
`else
            illegal = 1'b1;
`endif
        end
    end

`ifndef CRYPTO_SHA512_EN
    logic unused_hi;
    assign unused_hi = ^x[63:32];
`endif

    assign result = res64[XLEN-1:0];

endmodule

// File: rtl/crypto_sha2_pipe.sv
// Elastic valid/ready pipeline around crypto_sha2_core with tag, flush and stall.
// Optional SHA-512 ops are enabled by defining CRYPTO_SHA512_EN.
module crypto_sha2_pipe
    import crypto_instr_pkg::*;
#(
    parameter int XLEN        = CRYPTO_XLEN,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             illegal_o
);

    localparam int LAST = PIPE_STAGES - 1;

    sha2_stage_t            stage_q [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] valid_q;
    logic [PIPE_STAGES:0]   load;
    sha2_stage_t            in_raw;
    sha2_stage_t            core_src;
    sha2_stage_t            core_out;
    logic [XLEN-1:0]        core_result;
    logic                   core_illegal;

    always_comb begin
        in_raw      = '0;
        in_raw.op   = sha2_op_e'(op_i);
        in_raw.data = DATA_W'(rs1_i);
        in_raw.tag  = TAG_W_MAX'(tag_i);
    end

    // A stage may load when it is empty or its successor is loading this cycle.
    always_comb begin
        load              = '0;
        load[PIPE_STAGES] = ready_i;
        for (int k = LAST; k >= 0; k--) begin
            load[k] = !valid_q[k] || load[k+1];
        end
    end

    assign ready_o = load[0] || flush_i;

    // Single-stage builds compute straight from the inputs into the only register.
    assign core_src = (PIPE_STAGES == 1) ? in_raw : stage_q[0];

    crypto_sha2_core #(
        .XLEN (XLEN)
    ) u_core (
        .op      (core_src.op),
        .rs1     (core_src.data[XLEN-1:0]),
        .result  (core_result),
        .illegal (core_illegal)
    );

    always_comb begin
        core_out         = core_src;
        core_out.data    = DATA_W'(core_result);
        core_out.illegal = core_illegal;
    end

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        sha2_stage_t src;
        logic        src_valid;
        sha2_stage_t data_r;
        logic        valid_r;

        if (k == 0) begin : g_first
            assign src       = (PIPE_STAGES == 1) ? core_out : in_raw;
            assign src_valid = valid_i;
        end else if (k == 1) begin : g_compute
            assign src       = core_out;
            assign src_valid = valid_q[0];
        end else begin : g_carry
            assign src       = stage_q[k-1];
            assign src_valid = valid_q[k-1];
        end

        // Payload only moves with a valid op so a stalled or idle output stays put.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_r <= 1'b0;
                data_r  <= '0;
            end else if (flush_i) begin
                valid_r <= 1'b0;
            end else if (load[k]) begin
                valid_r <= src_valid;
                if (src_valid) begin
                    data_r <= src;
                end
            end
        end

        assign stage_q[k] = data_r;
        assign valid_q[k] = valid_r;
    end

    assign valid_o   = valid_q[LAST];
    assign result_o  = stage_q[LAST].data[XLEN-1:0];
    assign tag_o     = stage_q[LAST].tag[TAG_W-1:0];
    assign illegal_o = stage_q[LAST].illegal;

    logic unused_fields;
    assign unused_fields = ^{stage_q[LAST].op, stage_q[LAST].data, stage_q[LAST].tag,
                             stage_q[0].illegal};

endmodule

// File: tb/tb_crypto_sha2_pipe.sv
// Self-checking bench for crypto_sha2_pipe against a FIPS 180-4 reference model.
// Honours CRYPTO_SHA512_EN the same way the design does.
module tb_crypto_sha2_pipe;

    localparam int XLEN        = 64;
    localparam int PIPE_STAGES = 2;
    localparam int TAG_W       = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i;
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       op_i;
    logic [XLEN-1:0]  rs1_i;
    logic [TAG_W-1:0] tag_i;
    logic             valid_o;
    logic             ready_i;
    logic [XLEN-1:0]  result_o;
    logic [TAG_W-1:0] tag_o;
    logic             illegal_o;

    typedef struct {
        logic [63:0] res;
        logic [2:0]  tag;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          received = 0;
    logic [2:0]  tag_ctr = 3'd0;
    logic        hold_out = 1'b0;
    logic        prev_flush = 1'b0;
    logic [63:0] held_res;
    logic [2:0]  held_tag;
    logic        held_ill;

    always #5 clk = ~clk;

    crypto_sha2_pipe #(
        .XLEN        (XLEN),
        .PIPE_STAGES (PIPE_STAGES),
        .TAG_W       (TAG_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .flush_i   (flush_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .op_i      (op_i),
        .rs1_i     (rs1_i),
        .tag_i     (tag_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .tag_o     (tag_o),
        .illegal_o (illegal_o)
    );

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
        end
    endtask

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic void refModel(input int op, input logic [63:0] x,
                                     output logic [63:0] res, output logic ill);
        logic [31:0] w;
        logic [31:0] r;
        w   = x[31:0];
        r   = 32'd0;
        res = 64'd0;
        ill = 1'b0;
        case (op)
            0:       r = rotr32(w, 2) ^ rotr32(w, 13) ^ rotr32(w, 22);
            1:       r = rotr32(w, 6) ^ rotr32(w, 11) ^ rotr32(w, 25);
            2:       r = rotr32(w, 7) ^ rotr32(w, 18) ^ (w >> 3);
            3:       r = rotr32(w, 17) ^ rotr32(w, 19) ^ (w >> 10);
            default: r = 32'd0;
        endcase
        if (op < 4) begin
            res = {{32{r[31]}}, r};
        end else begin
`ifdef CRYPTO_SHA512_EN
            case (op)
                4:       res = rotr64(x, 28) ^ rotr64(x, 34) ^ rotr64(x, 39);
                5:       res = rotr64(x, 14) ^ rotr64(x, 18) ^ rotr64(x, 41);
                6:       res = rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
                default: res = rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
            endcase
`else
            ill = 1'b1;
`endif
        end
    endfunction

    // Per-cycle output monitor: stall stability, flush effect and scoreboard order.
    task automatic checkCycle();
        exp_t e;
        if (prev_flush) checkOutput("post_flush_valid", 64'(valid_o), 64'd0);
        if (hold_out) begin
            checkOutput("stall_valid", 64'(valid_o), 64'd1);
            checkOutput("stall_result", result_o, held_res);
            checkOutput("stall_tag", 64'(tag_o), 64'(held_tag));
            checkOutput("stall_illegal", 64'(illegal_o), 64'(held_ill));
        end
        if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", 64'(valid_o), 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("stream_result", result_o, e.res);
                checkOutput("stream_tag", 64'(tag_o), 64'(e.tag));
                checkOutput("stream_illegal", 64'(illegal_o), 64'(e.ill));
                received++;
            end
        end
        hold_out   = valid_o && !ready_i && !flush_i;
        held_res   = result_o;
        held_tag   = tag_o;
        held_ill   = illegal_o;
        if (flush_i) sb.delete();
        prev_flush = flush_i;
    endtask

    // Scripted mode: burst_ops ops back-to-back, ready_i low for cycles 3..5.
    task automatic applyStimulus(input int cycles, input bit random_mode, input int burst_ops);
        int          sent;
        logic        hold_in;
        logic [63:0] e_res;
        logic        e_ill;
        sent       = 0;
        hold_in    = 1'b0;
        hold_out   = 1'b0;
        prev_flush = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (!hold_in) begin
                valid_i = random_mode ? ($urandom_range(0, 3) != 0) : (sent < burst_ops);
                op_i    = 3'($urandom_range(0, 7));
                rs1_i   = {$urandom, $urandom};
                tag_i   = tag_ctr;
            end
            ready_i = random_mode ? ($urandom_range(0, 3) != 0) : !(c >= 3 && c < 6);
            flush_i = random_mode ? ($urandom_range(0, 39) == 0) : 1'b0;
            #1;
            checkCycle();
            hold_in = valid_i && !ready_o && !flush_i;
            if (valid_i && ready_o && !flush_i) begin
                refModel(int'(op_i), rs1_i, e_res, e_ill);
                sb.push_back('{e_res, tag_i, e_ill});
                tag_ctr++;
                sent++;
            end
        end
        @(negedge clk);
        valid_i = 1'b0;
        flush_i = 1'b0;
    endtask

    task automatic sendSingle(input logic [2:0] op, input logic [63:0] rs1, input logic [2:0] tag,
                              output logic [63:0] res, output logic [2:0] tag_out,
                              output logic ill, output int lat);
        @(negedge clk);
        valid_i = 1'b1;
        op_i    = op;
        rs1_i   = rs1;
        tag_i   = tag;
        ready_i = 1'b1;
        flush_i = 1'b0;
        #1;
        checkOutput("single_ready", 64'(ready_o), 64'd1);
        res     = '1;
        tag_out = '1;
        ill     = 1'b1;
        lat     = 20;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            valid_i = 1'b0;
            if (valid_o) begin
                res     = result_o;
                tag_out = tag_o;
                ill     = illegal_o;
                lat     = i;
                break;
            end
        end
    endtask

    initial begin
        logic [63:0] r;
        logic [2:0]  t;
        logic        il;
        int          lat;
        logic [63:0] e_res;
        logic        e_ill;
        logic [63:0] x;

        rst     = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        op_i    = 3'd0;
        rs1_i   = '0;
        tag_i   = '0;
        ready_i = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_valid", 64'(valid_o), 64'd0);
        checkOutput("reset_ready", 64'(ready_o), 64'd1);
        checkOutput("reset_result", result_o, 64'd0);
        checkOutput("reset_tag", 64'(tag_o), 64'd0);
        checkOutput("reset_illegal", 64'(illegal_o), 64'd0);

        sendSingle(3'd0, 64'd2, 3'd3, r, t, il, lat);
        checkOutput("sum0_result", r, 64'hFFFF_FFFF_8010_0800);
        checkOutput("sum0_tag", 64'(t), 64'd3);
        checkOutput("sum0_illegal", 64'(il), 64'd0);
        checkOutput("sum0_latency", 64'(lat), 64'(PIPE_STAGES));

        sendSingle(3'd2, 64'd1, 3'd6, r, t, il, lat);
        checkOutput("sig0_result", r, 64'h0000_0000_0200_4000);
        checkOutput("sig0_tag", 64'(t), 64'd6);

        sendSingle(3'd6, 64'd1, 3'd2, r, t, il, lat);
`ifdef CRYPTO_SHA512_EN
        checkOutput("sig512_result", r, 64'h8100_0000_0000_0000);
        checkOutput("sig512_illegal", 64'(il), 64'd0);
`else
        checkOutput("sig512_result", r, 64'd0);
        checkOutput("sig512_illegal", 64'(il), 64'd1);
`endif
        checkOutput("sig512_latency", 64'(lat), 64'(PIPE_STAGES));

        for (int op = 0; op < 8; op++) begin
            x = {$urandom, $urandom};
            refModel(op, x, e_res, e_ill);
            sendSingle(3'(op), x, 3'(op), r, t, il, lat);
            checkOutput("op_sweep_result", r, e_res);
            checkOutput("op_sweep_illegal", 64'(il), 64'(e_ill));
        end

        $display("[TB] burst of 8 ops with a 3-cycle downstream stall");
        received = 0;
        applyStimulus(20, 1'b0, 8);
        checkOutput("burst_count", 64'(received), 64'd8);
        checkOutput("burst_drained", 64'(sb.size()), 64'd0);

        $display("[TB] randomized traffic with stalls and flushes");
        applyStimulus(400, 1'b1, 0);
        applyStimulus(12, 1'b0, 0);
        checkOutput("random_drained", 64'(sb.size()), 64'd0);

        $display("[TB] flush with the pipe full");
        @(negedge clk);
        ready_i = 1'b0;
        valid_i = 1'b1;
        op_i    = 3'd1;
        rs1_i   = 64'h1234_5678_9abc_def0;
        tag_i   = 3'd5;
        repeat (PIPE_STAGES + 1) @(negedge clk);
        #1;
        checkOutput("full_ready", 64'(ready_o), 64'd0);
        checkOutput("full_valid", 64'(valid_o), 64'd1);
        flush_i = 1'b1;
        #1;
        checkOutput("flush_ready", 64'(ready_o), 64'd1);
        @(negedge clk);
        flush_i = 1'b0;
        valid_i = 1'b0;
        #1;
        checkOutput("flush_valid", 64'(valid_o), 64'd0);
        sendSingle(3'd0, 64'd2, 3'd4, r, t, il, lat);
        checkOutput("post_flush_result", r, 64'hFFFF_FFFF_8010_0800);
        checkOutput("post_flush_tag", 64'(t), 64'd4);
        checkOutput("post_flush_latency", 64'(lat), 64'(PIPE_STAGES));

        $display("[TB] asynchronous reset mid-operation");
        @(negedge clk);
        valid_i = 1'b1;
        op_i    = 3'd3;
        rs1_i   = 64'hFFFF_FFFF_FFFF_FFFF;
        tag_i   = 3'd7;
        ready_i = 1'b1;
        repeat (PIPE_STAGES) @(posedge clk);
        #2;
        valid_i = 1'b0;
        rst     = 1'b1;
        #1;
        checkOutput("async_reset_valid", 64'(valid_o), 64'd0);
        checkOutput("async_reset_result", result_o, 64'd0);
        checkOutput("async_reset_tag", 64'(tag_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < PIPE_STAGES + 2; i++) begin
            @(negedge clk);
            checkOutput("post_reset_idle", 64'(valid_o), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
